// File: rtl/hilo_muldiv_controller_if.sv
// Execute-stage <-> HI/LO sequencer connection: operation request, flush,
// MFHI/MFLO hazard input, and the HI/LO register-file write port.
interface hilo_muldiv_controller_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        abort;
  logic        hilo_read_request;
  logic        busy;
  logic        stall;
  logic        HI_write_enable;
  logic        LO_write_enable;
  logic [31:0] HI_write_data;
  logic [31:0] LO_write_data;

  modport master (
    output start, op, operand_a, operand_b, abort, hilo_read_request,
    input  busy, stall, HI_write_enable, LO_write_enable, HI_write_data, LO_write_data
  );

  modport slave (
    input  start, op, operand_a, operand_b, abort, hilo_read_request,
    output busy, stall, HI_write_enable, LO_write_enable, HI_write_data, LO_write_data
  );
endinterface

// File: rtl/hilo_muldiv_controller.sv
// MULT/MULTU/DIV/DIVU sequencer: 32-cycle radix-2 shift-add multiply or restoring
// divide on magnitudes, one sign-fix cycle, then a single-cycle HI/LO write.
module hilo_muldiv_controller #(
  parameter logic [31:0] DIV0_LO             = 32'hFFFFFFFF,
  parameter bit          DIV0_HI_IS_DIVIDEND = 1'b1
) (
  input logic                      clk,
  input logic                      reset,
  hilo_muldiv_controller_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

  logic [1:0]  state_reg;
  logic [4:0]  count_reg;
  logic        is_div_reg;
  logic        neg_result_reg;
  logic        neg_rem_reg;
  logic        div_zero_reg;
  logic [31:0] dividend_reg;
  logic [31:0] mcand_reg;     // multiplicand magnitude, or divisor magnitude
  logic [63:0] prod_reg;      // product; low half doubles as dividend/quotient shifter
  logic [31:0] rem_reg;
  logic [31:0] hi_data_reg;
  logic [31:0] lo_data_reg;

  // Operand magnitudes; 0x80000000 negates to itself, which is correct as unsigned.
  logic        signed_op;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign signed_op = ~bus.op[0];
  assign mag_a = (signed_op && bus.operand_a[31]) ? (~bus.operand_a + 32'd1) : bus.operand_a;
  assign mag_b = (signed_op && bus.operand_b[31]) ? (~bus.operand_b + 32'd1) : bus.operand_b;

  // Multiply iteration: conditional add into the upper half, carry kept, then shift right.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  assign mul_sum  = {1'b0, prod_reg[63:32]} + {1'b0, mcand_reg};
  assign mul_next = prod_reg[0] ? {mul_sum, prod_reg[31:1]} : {1'b0, prod_reg[63:1]};

  // Divide iteration: 33-bit partial remainder; it is always below twice the divisor,
  // so the borrow bit of the trial subtraction is an exact "does not fit" flag.
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_ge;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  assign div_shift = {rem_reg, prod_reg[31]};
  assign div_diff  = div_shift - {1'b0, mcand_reg};
  assign div_ge    = ~div_diff[32];
  assign rem_next  = div_ge ? div_diff[31:0] : div_shift[31:0];
  assign quo_next  = {prod_reg[30:0], div_ge};

  // Sign correction: quotient/product by operand-sign XOR, remainder follows dividend.
  logic [63:0] prod_fixed;
  logic [31:0] quo_fixed;
  logic [31:0] rem_fixed;
  logic [31:0] hi_next;
  logic [31:0] lo_next;

  always_comb begin
    prod_fixed = neg_result_reg ? (~prod_reg + 64'd1) : prod_reg;
    quo_fixed  = neg_result_reg ? (~prod_reg[31:0] + 32'd1) : prod_reg[31:0];
    rem_fixed  = neg_rem_reg ? (~rem_reg + 32'd1) : rem_reg;
    hi_next    = prod_fixed[63:32];
    lo_next    = prod_fixed[31:0];
    if (is_div_reg) begin
      if (div_zero_reg) begin
        hi_next = DIV0_HI_IS_DIVIDEND ? dividend_reg : 32'd0;
        lo_next = DIV0_LO;
      end else begin
        hi_next = rem_fixed;
        lo_next = quo_fixed;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      is_div_reg     <= 1'b0;
      neg_result_reg <= 1'b0;
      neg_rem_reg    <= 1'b0;
      div_zero_reg   <= 1'b0;
      dividend_reg   <= '0;
      mcand_reg      <= '0;
      prod_reg       <= '0;
      rem_reg        <= '0;
      hi_data_reg    <= '0;
      lo_data_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            state_reg      <= CALC;
            count_reg      <= '0;
            is_div_reg     <= bus.op[1];
            neg_result_reg <= signed_op & (bus.operand_a[31] ^ bus.operand_b[31]);
            neg_rem_reg    <= signed_op & bus.operand_a[31];
            div_zero_reg   <= (bus.operand_b == 32'd0);
            dividend_reg   <= bus.operand_a;
            mcand_reg      <= bus.op[1] ? mag_b : mag_a;
            prod_reg       <= {32'd0, (bus.op[1] ? mag_a : mag_b)};
            rem_reg        <= '0;
          end
        end
        CALC: begin
          if (bus.abort) begin
            state_reg <= IDLE;
          end else begin
            prod_reg  <= is_div_reg ? {32'd0, quo_next} : mul_next;
            if (is_div_reg)
              rem_reg <= rem_next;
            count_reg <= count_reg + 5'd1;
            if (count_reg == 5'd31)
              state_reg <= FIX;
          end
        end
        FIX: begin
          if (bus.abort) begin
            state_reg <= IDLE;
          end else begin
            hi_data_reg <= hi_next;
            lo_data_reg <= lo_next;
            state_reg   <= WR;
          end
        end
        // The instruction has committed by WR, so abort no longer cancels the write.
        WR:      state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy            = (state_reg != IDLE);
  assign bus.stall           = (bus.hilo_read_request | bus.start) & bus.busy;
  assign bus.HI_write_enable = (state_reg == WR);
  assign bus.LO_write_enable = (state_reg == WR);
  assign bus.HI_write_data   = hi_data_reg;
  assign bus.LO_write_data   = lo_data_reg;

endmodule

// File: tb/tb_hilo_muldiv_controller.sv
// Scoreboard bench: two instances (divide-by-zero HI = dividend / HI = 0) share one
// stimulus stream; monitors pop expected HI/LO writes and the cycle they must occur in.
module tb_hilo_muldiv_controller;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hilo_muldiv_controller_if bus1 ();
  hilo_muldiv_controller_if bus2 ();

  assign bus2.start             = bus1.start;
  assign bus2.op                = bus1.op;
  assign bus2.operand_a         = bus1.operand_a;
  assign bus2.operand_b         = bus1.operand_b;
  assign bus2.abort             = bus1.abort;
  assign bus2.hilo_read_request = bus1.hilo_read_request;

  hilo_muldiv_controller #(.DIV0_LO(32'hFFFFFFFF), .DIV0_HI_IS_DIVIDEND(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  hilo_muldiv_controller #(.DIV0_LO(32'hFFFFFFFF), .DIV0_HI_IS_DIVIDEND(1'b0)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc + 1);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // Cycle numbering: a value sampled at negedge belongs to cycle cyc+1.
  always @(negedge clk) begin
    exp_t e;
    if (bus1.HI_write_enable === 1'b1 || bus1.LO_write_enable === 1'b1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut1_unexpected_write cycle=%0d hi=%h lo=%h required=none",
                 cyc + 1, bus1.HI_write_data, bus1.LO_write_data);
      end else begin
        e = q1.pop_front();
        check("dut1_wr_cycle", 64'(cyc + 1), 64'(e.cyc));
        check("dut1_enables", {62'd0, bus1.HI_write_enable, bus1.LO_write_enable}, 64'd3);
        check("dut1_hi", {32'd0, bus1.HI_write_data}, {32'd0, e.hi});
        check("dut1_lo", {32'd0, bus1.LO_write_data}, {32'd0, e.lo});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus2.HI_write_enable === 1'b1 || bus2.LO_write_enable === 1'b1) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("FAIL dut2_unexpected_write cycle=%0d hi=%h lo=%h required=none",
                 cyc + 1, bus2.HI_write_data, bus2.LO_write_data);
      end else begin
        e = q2.pop_front();
        check("dut2_wr_cycle", 64'(cyc + 1), 64'(e.cyc));
        check("dut2_hi", {32'd0, bus2.HI_write_data}, {32'd0, e.hi});
        check("dut2_lo", {32'd0, bus2.LO_write_data}, {32'd0, e.lo});
      end
    end
  end

  // Issue one operation at cycle k and walk it cycle by cycle. Offsets are relative
  // to k; 0 disables. abort in 1..33 or any reset kills the op (nothing expected).
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi1, input logic [31:0] lo,
                        input logic [31:0] hi2, input int rr_at, input int restart_at,
                        input int abort_at, input int reset_at);
    int k, kill, last;
    bit busy_ok, stall_ok, bexp, sexp, rrv;
    kill = 0;
    if (abort_at >= 1 && abort_at <= 33) kill = abort_at;
    if (reset_at >= 1) kill = reset_at;
    last = (kill != 0) ? kill + 1 : 35;
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = o; bus1.operand_a = a; bus1.operand_b = b;
    bus1.abort = 1'b0; bus1.hilo_read_request = 1'b0; reset = 1'b0;
    k = cyc + 1;
    $display("[TB] %s issued at cycle %0d a=%h b=%h", name, k, a, b);
    if (kill == 0) begin
      q1.push_back('{hi: hi1, lo: lo, cyc: k + 34});
      q2.push_back('{hi: hi2, lo: lo, cyc: k + 34});
    end
    busy_ok = 1'b1;
    stall_ok = 1'b1;
    for (int j = 1; j <= last; j++) begin
      @(negedge clk);
      bus1.start = (j == restart_at);
      if (j == restart_at) begin
        bus1.operand_a = 32'd5;
        bus1.operand_b = 32'd5;
      end
      bus1.abort = (j == abort_at);
      reset = (j == reset_at);
      rrv = (rr_at != 0) && (j >= rr_at);
      bus1.hilo_read_request = rrv;
      #1;
      bexp = (j <= 34) && (kill == 0 || j <= kill);
      sexp = bexp && (rrv || j == restart_at);
      if (bus1.busy !== bexp) begin
        if (busy_ok) $display("[TB] %s busy=%b at k+%0d", name, bus1.busy, j);
        busy_ok = 1'b0;
      end
      if (bus1.stall !== sexp) begin
        if (stall_ok) $display("[TB] %s stall=%b at k+%0d", name, bus1.stall, j);
        stall_ok = 1'b0;
      end
    end
    check({name, "_busy_window"}, {63'd0, busy_ok}, 64'd1);
    if (rr_at != 0 || restart_at != 0)
      check({name, "_stall_window"}, {63'd0, stall_ok}, 64'd1);
    if (reset_at != 0)
      check({name, "_reset_data"}, {bus1.HI_write_data, bus1.LO_write_data}, 64'd0);
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.hilo_read_request = 1'b0; reset = 1'b0;
  endtask

  initial begin
    int k;
    reset = 1'b1;
    bus1.start = 1'b0; bus1.op = 2'b00; bus1.operand_a = '0; bus1.operand_b = '0;
    bus1.abort = 1'b0; bus1.hilo_read_request = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check("reset_busy", {63'd0, bus1.busy}, 64'd0);
    check("reset_enables", {62'd0, bus1.HI_write_enable, bus1.LO_write_enable}, 64'd0);
    check("reset_data", {bus1.HI_write_data, bus1.LO_write_data}, 64'd0);
    bus1.hilo_read_request = 1'b1; #1;
    check("idle_read_no_stall", {63'd0, bus1.stall}, 64'd0);
    bus1.hilo_read_request = 1'b0;

    //      name          op     a             b             hi1           lo            hi2          rr rs ab rst
    run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0, 0);
    run_op("mult_m3x5",  2'b00, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 32'hFFFFFFFF, 0, 0, 0, 0);
    run_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 32'h40000000, 0, 0, 0, 0);
    run_op("div_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0, 0);
    run_op("div_7_m2",   2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 32'd1,        0, 0, 0, 0);
    run_op("divu_100_7", 2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       32'd2,        0, 0, 0, 0);
    run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 32'd0,        0, 0, 0, 0);
    run_op("divu_zero",  2'b11, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 32'd0,        0, 0, 0, 0);
    run_op("div_neg_z",  2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 32'd0,        0, 0, 0, 0);
    run_op("read_stall", 2'b01, 32'h12345678, 32'h10,       32'h00000001, 32'h23456780, 32'h00000001, 5, 0, 0, 0);
    run_op("restart",    2'b11, 32'd1000,     32'd10,       32'd0,        32'd100,      32'd0,        0, 10, 0, 0);
    run_op("abort_wr",   2'b01, 32'd6,        32'd7,        32'd0,        32'd42,       32'd0,        0, 0, 34, 0);
    run_op("abort_calc", 2'b01, 32'd2,        32'd3,        32'd0,        32'd0,        32'd0,        0, 0, 20, 0);
    run_op("reset_mid",  2'b11, 32'd9,        32'd3,        32'd0,        32'd0,        32'd0,        0, 0, 0, 20);
    // Starts at k+22 of the reset op, so its write lands at k+56.
    run_op("after_rst",  2'b00, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFF, 0, 0, 0, 0);

    // abort together with start in IDLE drops the start
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = 2'b01; bus1.operand_a = 32'd9; bus1.operand_b = 32'd9;
    bus1.abort = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0; bus1.abort = 1'b0; #1;
    check("abort_start_idle_busy", {63'd0, bus1.busy}, 64'd0);

    // start during WR is ignored; held into the following IDLE cycle it is accepted
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = 2'b01; bus1.operand_a = 32'd3; bus1.operand_b = 32'd4;
    k = cyc + 1;
    $display("[TB] chain_a issued at cycle %0d", k);
    q1.push_back('{hi: 32'd0, lo: 32'd12, cyc: k + 34});
    q2.push_back('{hi: 32'd0, lo: 32'd12, cyc: k + 34});
    for (int j = 1; j <= 33; j++) begin
      @(negedge clk);
      bus1.start = 1'b0;
    end
    @(negedge clk);
    bus1.start = 1'b1; bus1.op = 2'b11; bus1.operand_a = 32'd100; bus1.operand_b = 32'd7;
    q1.push_back('{hi: 32'd2, lo: 32'd14, cyc: k + 69});
    q2.push_back('{hi: 32'd2, lo: 32'd14, cyc: k + 69});
    #1;
    check("chain_wr_start_stall", {63'd0, bus1.stall}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    bus1.start = 1'b0;
    repeat (40) @(negedge clk);

    check("dut1_queue_drained", 64'(q1.size()), 64'd0);
    check("dut2_queue_drained", 64'(q2.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
